// File: rtl/sensor_input_conditioner.sv
// sensor_input_conditioner
//   Board-pin front end for the irrigation controller. Every raw probe,
//   button and switch is synchronised, debounced, then decoded into
//   registered level outputs and single-cycle button pulses.
//
// Ports
//   clock, reset        rising-edge clock, async active-high reset
//   p_lo/p_mid/p_hi     raw level probes (1 = wet)
//   btn_bs/vs/ve        raw push-buttons (1 = pressed)
//   sw_al, sw_fault     raw alarm and external fault switches
//   H, M, L             decoded level band
//   Bs, Vs, Ve          one-cycle button press pulses
//   Al                  debounced alarm level
//   E, err_code         fault flag and cause {external, probe inconsistency}

// One debounce channel: 2-flop synchroniser followed by a stability counter.
// st only follows s2 after DEB_CYCLES consecutive disagreeing samples.
module sic_debounce #(
    parameter int DEB_CYCLES = 500000,
    parameter int CNT_W      = 20
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic st
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            st  <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == st) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                st  <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module sensor_input_conditioner #(
    parameter int DEB_CYCLES = 500000,
    parameter int CNT_W      = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       p_lo,
    input  logic       p_mid,
    input  logic       p_hi,
    input  logic       btn_bs,
    input  logic       btn_vs,
    input  logic       btn_ve,
    input  logic       sw_al,
    input  logic       sw_fault,
    output logic       H,
    output logic       M,
    output logic       L,
    output logic       Bs,
    output logic       Vs,
    output logic       Ve,
    output logic       Al,
    output logic       E,
    output logic [1:0] err_code
);
    localparam int NUM_CH = 8;
    localparam int CH_LO  = 0;
    localparam int CH_MID = 1;
    localparam int CH_HI  = 2;
    localparam int CH_BS  = 3;
    localparam int CH_VS  = 4;
    localparam int CH_VE  = 5;
    localparam int CH_AL  = 6;
    localparam int CH_FLT = 7;

    logic [NUM_CH-1:0] raw;
    logic [NUM_CH-1:0] st;
    logic [2:0]        btn_d;     // previous stable {ve, vs, bs}
    logic [2:0]        btn_rise;
    logic              inc;
    logic              fault_nxt;

    assign raw = {sw_fault, sw_al, btn_ve, btn_vs, btn_bs, p_hi, p_mid, p_lo};

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            sic_debounce #(
                .DEB_CYCLES(DEB_CYCLES),
                .CNT_W     (CNT_W)
            ) u_deb (
                .clock(clock),
                .reset(reset),
                .raw  (raw[i]),
                .st   (st[i])
            );
        end
    endgenerate

    // A wet probe above a dry one is physically impossible.
    assign inc       = (st[CH_HI] & ~st[CH_MID]) | (st[CH_MID] & ~st[CH_LO]);
    assign fault_nxt = inc | st[CH_FLT];
    assign btn_rise  = st[CH_VE:CH_BS] & ~btn_d;

    // Pulses are gated with the E value being registered on the same edge,
    // so a pulse can never coincide with E=1; gated edges are simply lost.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            btn_d    <= '0;
            H        <= 1'b0;
            M        <= 1'b0;
            L        <= 1'b0;
            Bs       <= 1'b0;
            Vs       <= 1'b0;
            Ve       <= 1'b0;
            Al       <= 1'b0;
            E        <= 1'b0;
            err_code <= 2'b00;
        end else begin
            btn_d    <= st[CH_VE:CH_BS];
            H        <= st[CH_HI];
            M        <= st[CH_MID] & ~st[CH_HI];
            L        <= ~st[CH_MID];
            Al       <= st[CH_AL];
            E        <= fault_nxt;
            err_code <= {st[CH_FLT], inc};
            Bs       <= btn_rise[0] & ~fault_nxt;
            // Sprinkler select wins a same-cycle tie; drip select is dropped.
            Vs       <= btn_rise[1] & ~btn_rise[0] & ~fault_nxt;
            Ve       <= btn_rise[2] & ~fault_nxt;
        end
    end
endmodule

// File: tb/tb_sensor_input_conditioner.sv
module tb_sensor_input_conditioner;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       p_lo = 0, p_mid = 0, p_hi = 0;
    logic       btn_bs = 0, btn_vs = 0, btn_ve = 0;
    logic       sw_al = 0, sw_fault = 0;
    logic       H, M, L, Bs, Vs, Ve, Al, E;
    logic [1:0] err_code;

    typedef struct packed {
        logic [2:0] p;    // {Bs, Vs, Ve}
        int         cyc;
    } pulse_t;

    pulse_t exp_q[$];
    pulse_t obs_q[$];
    int     cyc   = 0;
    int     total = 0;
    int     bad   = 0;

    sensor_input_conditioner #(.DEB_CYCLES(4), .CNT_W(3)) dut (
        .clock(clock), .reset(reset),
        .p_lo(p_lo), .p_mid(p_mid), .p_hi(p_hi),
        .btn_bs(btn_bs), .btn_vs(btn_vs), .btn_ve(btn_ve),
        .sw_al(sw_al), .sw_fault(sw_fault),
        .H(H), .M(M), .L(L), .Bs(Bs), .Vs(Vs), .Ve(Ve),
        .Al(Al), .E(E), .err_code(err_code)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Advance to the falling edge of cycle c, logging any pulse seen on the way.
    task automatic run_to(input int c);
        while (cyc < c) begin
            @(negedge clock);
            if (!reset && (Bs || Vs || Ve))
                obs_q.push_back('{p: {Bs, Vs, Ve}, cyc: cyc});
        end
    endtask

    task automatic test_reset();
        int d;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        total++;
        if ({H, M, L, Bs, Vs, Ve, Al, E, err_code} !== 10'b0)
            begin bad++; $display("FAIL reset_hold got=%b want=%b", {H, M, L, Bs, Vs, Ve, Al, E, err_code}, 10'b0); end
        @(posedge clock); #1 reset = 1'b0; d = cyc;
        run_to(d + 1);
        total++;
        if ({H, M, L, Bs, Vs, Ve, Al, E, err_code} !== 10'b0010000000)
            begin bad++; $display("FAIL reset_release got=%b want=%b", {H, M, L, Bs, Vs, Ve, Al, E, err_code}, 10'b0010000000); end
    endtask

    task automatic test_levels();
        int d;
        @(posedge clock); #1 p_lo = 1'b1; sw_al = 1'b1; d = cyc;
        run_to(d + 6);
        total++;
        if (Al !== 1'b0) begin bad++; $display("FAIL al_early got=%b want=0", Al); end
        run_to(d + 7);
        total++;
        if ({H, M, L, Al, E, err_code} !== 7'b0011000)
            begin bad++; $display("FAIL lo_wet got=%b want=%b", {H, M, L, Al, E, err_code}, 7'b0011000); end
        run_to(d + 10);
        @(posedge clock); #1 p_mid = 1'b1; d = cyc;
        run_to(d + 6);
        total++;
        if ({M, L} !== 2'b01) begin bad++; $display("FAIL mid_early got=%b want=01", {M, L}); end
        run_to(d + 7);
        total++;
        if ({H, M, L, Al, E, err_code} !== 7'b0101000)
            begin bad++; $display("FAIL mid_wet got=%b want=%b", {H, M, L, Al, E, err_code}, 7'b0101000); end
        run_to(d + 10);
        @(posedge clock); #1 p_hi = 1'b1; d = cyc;
        run_to(d + 6);
        total++;
        if ({H, M} !== 2'b01) begin bad++; $display("FAIL hi_early got=%b want=01", {H, M}); end
        run_to(d + 7);
        total++;
        if ({H, M, L, Al, E, err_code} !== 7'b1001000)
            begin bad++; $display("FAIL hi_wet got=%b want=%b", {H, M, L, Al, E, err_code}, 7'b1001000); end
        run_to(d + 10);
    endtask

    task automatic test_bs_press();
        int d;
        pulse_t e, o;
        // Three sampled cycles high is one short of the debounce window.
        @(posedge clock); #1 btn_bs = 1'b1; d = cyc;
        run_to(d + 2);
        @(posedge clock); #1 btn_bs = 1'b0; d = cyc;
        run_to(d + 12);
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL bs_glitch got=%0d pulses want=0", obs_q.size()); end
        obs_q.delete();
        @(posedge clock); #1 btn_bs = 1'b1; d = cyc;
        exp_q.push_back('{p: 3'b100, cyc: d + 7});
        run_to(d + 9);
        @(posedge clock); #1 btn_bs = 1'b0; d = cyc;
        run_to(d + 12);
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            total++;
            if (exp_q.size() == 0) begin
                o = obs_q.pop_front(); bad++;
                $display("FAIL bs_press extra got=%b@%0d want=none", o.p, o.cyc);
            end else if (obs_q.size() == 0) begin
                e = exp_q.pop_front(); bad++;
                $display("FAIL bs_press missing got=none want=%b@%0d", e.p, e.cyc);
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin bad++; $display("FAIL bs_press got=%b@%0d want=%b@%0d", o.p, o.cyc, e.p, e.cyc); end
            end
        end
    endtask

    task automatic test_simultaneous();
        int d;
        pulse_t e, o;
        @(posedge clock); #1 btn_bs = 1'b1; btn_vs = 1'b1; d = cyc;
        exp_q.push_back('{p: 3'b100, cyc: d + 7});
        run_to(d + 9);
        @(posedge clock); #1 btn_bs = 1'b0; btn_vs = 1'b0; d = cyc;
        run_to(d + 12);
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            total++;
            if (exp_q.size() == 0) begin
                o = obs_q.pop_front(); bad++;
                $display("FAIL bs_vs_tie extra got=%b@%0d want=none", o.p, o.cyc);
            end else if (obs_q.size() == 0) begin
                e = exp_q.pop_front(); bad++;
                $display("FAIL bs_vs_tie missing got=none want=%b@%0d", e.p, e.cyc);
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin bad++; $display("FAIL bs_vs_tie got=%b@%0d want=%b@%0d", o.p, o.cyc, e.p, e.cyc); end
            end
        end
    endtask

    task automatic test_fault();
        int d;
        @(posedge clock); #1 p_mid = 1'b0; d = cyc;
        run_to(d + 6);
        total++;
        if ({E, err_code} !== 3'b000) begin bad++; $display("FAIL inc_early got=%b want=000", {E, err_code}); end
        run_to(d + 7);
        total++;
        if ({H, M, L, Al, E, err_code} !== 7'b1011101)
            begin bad++; $display("FAIL inc_set got=%b want=%b", {H, M, L, Al, E, err_code}, 7'b1011101); end
        run_to(d + 9);
        @(posedge clock); #1 sw_fault = 1'b1; d = cyc;
        run_to(d + 7);
        total++;
        if ({E, err_code} !== 3'b111) begin bad++; $display("FAIL both_fault got=%b want=111", {E, err_code}); end
        run_to(d + 9);
        @(posedge clock); #1 btn_ve = 1'b1; d = cyc;
        run_to(d + 9);
        @(posedge clock); #1 btn_ve = 1'b0; d = cyc;
        run_to(d + 10);
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL ve_gated got=%0d pulses want=0", obs_q.size()); end
        obs_q.delete();
        @(posedge clock); #1 p_mid = 1'b1; sw_fault = 1'b0; d = cyc;
        run_to(d + 6);
        total++;
        if ({E, err_code} !== 3'b111) begin bad++; $display("FAIL fault_hold got=%b want=111", {E, err_code}); end
        run_to(d + 7);
        total++;
        if ({H, M, L, Al, E, err_code} !== 7'b1001000)
            begin bad++; $display("FAIL fault_clear got=%b want=%b", {H, M, L, Al, E, err_code}, 7'b1001000); end
        run_to(d + 10);
    endtask

    task automatic test_reset_mid();
        int d, r;
        pulse_t e, o;
        @(posedge clock); #1 btn_ve = 1'b1; d = cyc;
        run_to(d + 2);
        @(posedge clock); #1 reset = 1'b1;
        #1;
        total++;
        if ({H, M, L, Bs, Vs, Ve, Al, E, err_code} !== 10'b0)
            begin bad++; $display("FAIL reset_async got=%b want=%b", {H, M, L, Bs, Vs, Ve, Al, E, err_code}, 10'b0); end
        @(posedge clock);
        @(posedge clock); #1 reset = 1'b0; r = cyc;
        exp_q.push_back('{p: 3'b001, cyc: r + 7});
        run_to(r + 1);
        total++;
        if ({H, M, L, Al, E, err_code} !== 7'b0010000)
            begin bad++; $display("FAIL rst_redeb got=%b want=%b", {H, M, L, Al, E, err_code}, 7'b0010000); end
        run_to(r + 7);
        total++;
        if ({H, M, L, Al, E, err_code} !== 7'b1001000)
            begin bad++; $display("FAIL rst_settle got=%b want=%b", {H, M, L, Al, E, err_code}, 7'b1001000); end
        run_to(r + 10);
        @(posedge clock); #1 btn_ve = 1'b0; d = cyc;
        run_to(d + 10);
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            total++;
            if (exp_q.size() == 0) begin
                o = obs_q.pop_front(); bad++;
                $display("FAIL ve_after_rst extra got=%b@%0d want=none", o.p, o.cyc);
            end else if (obs_q.size() == 0) begin
                e = exp_q.pop_front(); bad++;
                $display("FAIL ve_after_rst missing got=none want=%b@%0d", e.p, e.cyc);
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin bad++; $display("FAIL ve_after_rst got=%b@%0d want=%b@%0d", o.p, o.cyc, e.p, e.cyc); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_levels();
        test_bs_press();
        test_simultaneous();
        test_fault();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
